// File: rtl/alb_mss_fab_ibp_dly_if.sv
// IBP bundle (command, write data, read response, write response) between a master and a slave.
// The master modport drives commands, write data and response accepts; the slave modport drives the rest.
interface alb_mss_fab_ibp_dly_if #(
  parameter int a_w = 32,
  parameter int d_w = 32
);
  logic             cmd_valid;
  logic             cmd_accept;
  logic             cmd_read;
  logic [a_w-1:0]   cmd_addr;
  logic             cmd_wrap;
  logic [2:0]       cmd_data_size;
  logic [3:0]       cmd_burst_size;
  logic [1:0]       cmd_prot;
  logic [3:0]       cmd_cache;
  logic             cmd_lock;
  logic             cmd_excl;

  logic             wr_valid;
  logic             wr_accept;
  logic [d_w-1:0]   wr_data;
  logic [d_w/8-1:0] wr_mask;
  logic             wr_last;

  logic             rd_valid;
  logic             rd_accept;
  logic [d_w-1:0]   rd_data;
  logic             rd_last;
  logic             err_rd;
  logic             rd_excl_ok;

  logic             wr_done;
  logic             wr_excl_done;
  logic             err_wr;
  logic             wr_resp_accept;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wrap, cmd_data_size, cmd_burst_size,
           cmd_prot, cmd_cache, cmd_lock, cmd_excl,
    input  cmd_accept,
    output wr_valid, wr_data, wr_mask, wr_last,
    input  wr_accept,
    input  rd_valid, rd_data, rd_last, err_rd, rd_excl_ok,
    output rd_accept,
    input  wr_done, wr_excl_done, err_wr,
    output wr_resp_accept
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wrap, cmd_data_size, cmd_burst_size,
           cmd_prot, cmd_cache, cmd_lock, cmd_excl,
    output cmd_accept,
    input  wr_valid, wr_data, wr_mask, wr_last,
    output wr_accept,
    output rd_valid, rd_data, rd_last, err_rd, rd_excl_ok,
    input  rd_accept,
    output wr_done, wr_excl_done, err_wr,
    input  wr_resp_accept
  );
endinterface

// File: rtl/alb_mss_fab_ibp_dly.sv
// IBP command latency/gap/outstanding-cap injector; queued commands issue in order after max(L,1) cycles.
// Upstream backpressure only when the queue is full; data/response channels are zero-latency wires. Stats: ALB_MSS_FAB_IBP_DLY_STATS_EN.
module alb_mss_fab_ibp_dly #(
  parameter int a_w   = 32,
  parameter int d_w   = 32,
  parameter int depl2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_a,
  alb_mss_fab_ibp_dly_if.slave  i_ibp,
  alb_mss_fab_ibp_dly_if.master o_ibp,
  input  logic [11:0]           cfg_lat_r,
  input  logic [11:0]           cfg_lat_w,
  input  logic [7:0]            cfg_cmd_gap,
  input  logic [7:0]            cfg_max_out,
  output logic [31:0]           stat_cmd_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int DEPTH = 1 << depl2;

  typedef struct packed {
    logic           read;
    logic [a_w-1:0] addr;
    logic           wrap;
    logic [2:0]     data_size;
    logic [3:0]     burst_size;
    logic [1:0]     prot;
    logic [3:0]     cache;
    logic           lock;
    logic           excl;
    logic [12:0]    ts;
  } cmd_t;

  logic [12:0]      r_now;
  logic [depl2:0]   r_wr_ptr;
  logic [depl2:0]   r_rd_ptr;
  cmd_t             r_q [DEPTH];
  logic [DEPTH-1:0] r_mat;
  logic             r_cmd_accept;
  logic [7:0]       r_gap_cnt;
  logic [7:0]       r_out_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [depl2:0]   w_wr_ptr_nxt;
  logic [depl2:0]   w_rd_ptr_nxt;
  logic             w_full_nxt;
  logic [depl2-1:0] w_wr_idx;
  logic [depl2-1:0] w_rd_idx;
  cmd_t             w_new;
  cmd_t             w_head;
  logic [DEPTH-1:0] w_slot_mat;
  logic [DEPTH-1:0] w_clr;
  logic             w_head_mat;
  logic             w_out_ok;
  logic             w_dec_rd;
  logic             w_dec_wr;
  logic [8:0]       w_out_add;
  logic [8:0]       w_out_sub;
  logic [8:0]       w_out_diff;
  logic [7:0]       w_out_nxt;

  assign w_wr_idx     = r_wr_ptr[depl2-1:0];
  assign w_rd_idx     = r_rd_ptr[depl2-1:0];
  assign w_push       = i_ibp.cmd_valid & r_cmd_accept;
  assign w_pop        = o_ibp.cmd_valid & o_ibp.cmd_accept;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_wr_ptr_nxt = r_wr_ptr + {{depl2{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{depl2{1'b0}}, w_pop};
  assign w_full_nxt   = (w_wr_ptr_nxt[depl2] != w_rd_ptr_nxt[depl2]) &&
                        (w_wr_ptr_nxt[depl2-1:0] == w_rd_ptr_nxt[depl2-1:0]);

  always_comb begin
    w_new            = '0;
    w_new.read       = i_ibp.cmd_read;
    w_new.addr       = i_ibp.cmd_addr;
    w_new.wrap       = i_ibp.cmd_wrap;
    w_new.data_size  = i_ibp.cmd_data_size;
    w_new.burst_size = i_ibp.cmd_burst_size;
    w_new.prot       = i_ibp.cmd_prot;
    w_new.cache      = i_ibp.cmd_cache;
    w_new.lock       = i_ibp.cmd_lock;
    w_new.excl       = i_ibp.cmd_excl;
    w_new.ts         = r_now;
  end

  // Latency is re-read every cycle so config changes hit unmatured entries; maturity is then sticky.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mat
    logic [11:0] w_lat;
    logic [12:0] w_diff;
    assign w_lat          = r_q[gi].read ? cfg_lat_r : cfg_lat_w;
    assign w_diff         = r_now - r_q[gi].ts;
    assign w_slot_mat[gi] = (w_diff >= {1'b0, w_lat});
  end

  assign w_clr      = w_push ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_wr_idx) : '0;
  assign w_head     = r_q[w_rd_idx];
  assign w_head_mat = !w_empty && (r_mat[w_rd_idx] || w_slot_mat[w_rd_idx]);
  assign w_out_ok   = (cfg_max_out == 8'd0) || (r_out_cnt < cfg_max_out);

  assign o_ibp.cmd_valid      = w_head_mat && (r_gap_cnt == 8'd0) && w_out_ok;
  assign o_ibp.cmd_read       = w_head.read;
  assign o_ibp.cmd_addr       = w_head.addr;
  assign o_ibp.cmd_wrap       = w_head.wrap;
  assign o_ibp.cmd_data_size  = w_head.data_size;
  assign o_ibp.cmd_burst_size = w_head.burst_size;
  assign o_ibp.cmd_prot       = w_head.prot;
  assign o_ibp.cmd_cache      = w_head.cache;
  assign o_ibp.cmd_lock       = w_head.lock;
  assign o_ibp.cmd_excl       = w_head.excl;
  assign i_ibp.cmd_accept     = r_cmd_accept;

  assign o_ibp.wr_valid       = i_ibp.wr_valid;
  assign o_ibp.wr_data        = i_ibp.wr_data;
  assign o_ibp.wr_mask        = i_ibp.wr_mask;
  assign o_ibp.wr_last        = i_ibp.wr_last;
  assign i_ibp.wr_accept      = o_ibp.wr_accept;
  assign i_ibp.rd_valid       = o_ibp.rd_valid;
  assign i_ibp.rd_data        = o_ibp.rd_data;
  assign i_ibp.rd_last        = o_ibp.rd_last;
  assign i_ibp.err_rd         = o_ibp.err_rd;
  assign i_ibp.rd_excl_ok     = o_ibp.rd_excl_ok;
  assign o_ibp.rd_accept      = i_ibp.rd_accept;
  assign i_ibp.wr_done        = o_ibp.wr_done;
  assign i_ibp.wr_excl_done   = o_ibp.wr_excl_done;
  assign i_ibp.err_wr         = o_ibp.err_wr;
  assign o_ibp.wr_resp_accept = i_ibp.wr_resp_accept;

  // Up to one issue and two retirements per cycle; result clamps to [0,255].
  assign w_dec_rd   = (o_ibp.rd_valid | o_ibp.err_rd) & o_ibp.rd_last & i_ibp.rd_accept;
  assign w_dec_wr   = (o_ibp.wr_done | o_ibp.wr_excl_done | o_ibp.err_wr) & i_ibp.wr_resp_accept;
  assign w_out_add  = {1'b0, r_out_cnt} + {8'd0, w_pop};
  assign w_out_sub  = {8'd0, w_dec_rd} + {8'd0, w_dec_wr};
  assign w_out_diff = w_out_add - w_out_sub;
  assign w_out_nxt  = (w_out_add < w_out_sub) ? 8'd0 :
                      (w_out_diff[8] ? 8'hff : w_out_diff[7:0]);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_now        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cmd_accept <= 1'b0;
      r_gap_cnt    <= '0;
      r_out_cnt    <= '0;
    end else begin
      r_now        <= r_now + 13'd1;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_cmd_accept <= !w_full_nxt;
      r_out_cnt    <= w_out_nxt;
      if (w_pop) begin
        r_gap_cnt <= cfg_cmd_gap;
      end else if (r_gap_cnt != 8'd0) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_mat <= '0;
    end else begin
      if (w_push) r_q[w_wr_idx] <= w_new;
      r_mat <= (r_mat | w_slot_mat) & ~w_clr;
    end
  end

`ifdef ALB_MSS_FAB_IBP_DLY_STATS_EN
  logic [31:0] r_stat_cmd;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_stat_cmd   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop && (r_stat_cmd != 32'hffff_ffff)) r_stat_cmd <= r_stat_cmd + 32'd1;
      if (w_head_mat && !w_pop && (r_stat_stall != 32'hffff_ffff)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_cmd_cnt   = r_stat_cmd;
  assign stat_stall_cnt = r_stat_stall;
`else
  assign stat_cmd_cnt   = 32'd0;
  assign stat_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alb_mss_fab_ibp_dly.sv
// Directed bench for the IBP delay injector: latency, gap, outstanding cap, full queue, timestamp wrap.
module tb_alb_mss_fab_ibp_dly;

  logic        clk;
  logic        rst_a;
  logic [11:0] cfg_lat_r;
  logic [11:0] cfg_lat_w;
  logic [7:0]  cfg_cmd_gap;
  logic [7:0]  cfg_max_out;
  logic [31:0] stat_cmd_cnt;
  logic [31:0] stat_stall_cnt;

  alb_mss_fab_ibp_dly_if #(.a_w(32), .d_w(32)) up ();
  alb_mss_fab_ibp_dly_if #(.a_w(32), .d_w(32)) dn ();

  alb_mss_fab_ibp_dly #(.a_w(32), .d_w(32), .depl2(5)) u_dut (
    .clk            (clk),
    .rst_a          (rst_a),
    .i_ibp          (up.slave),
    .o_ibp          (dn.master),
    .cfg_lat_r      (cfg_lat_r),
    .cfg_lat_w      (cfg_lat_w),
    .cfg_cmd_gap    (cfg_cmd_gap),
    .cfg_max_out    (cfg_max_out),
    .stat_cmd_cnt   (stat_cmd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int first_vld = -1;
  int hs_q[$];
  int iss_q[$];
  logic [31:0] iss_addr_q[$];
  logic        iss_read;
  logic [2:0]  iss_ds;
  logic [3:0]  iss_bs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (up.cmd_valid && up.cmd_accept) hs_q.push_back(cyc);
      if (dn.cmd_valid && dn.cmd_accept) begin
        iss_q.push_back(cyc);
        iss_addr_q.push_back(dn.cmd_addr);
        iss_read = dn.cmd_read;
        iss_ds   = dn.cmd_data_size;
        iss_bs   = dn.cmd_burst_size;
      end
      if (dn.cmd_valid && first_vld < 0) first_vld = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    up.cmd_valid = 0; up.cmd_read = 0; up.cmd_addr = 0; up.cmd_wrap = 0;
    up.cmd_data_size = 0; up.cmd_burst_size = 0; up.cmd_prot = 0; up.cmd_cache = 0;
    up.cmd_lock = 0; up.cmd_excl = 0;
    up.wr_valid = 0; up.wr_data = 0; up.wr_mask = 0; up.wr_last = 0;
    up.rd_accept = 1; up.wr_resp_accept = 1;
    dn.cmd_accept = 1; dn.wr_accept = 1;
    dn.rd_valid = 0; dn.rd_data = 0; dn.rd_last = 0; dn.err_rd = 0; dn.rd_excl_ok = 0;
    dn.wr_done = 0; dn.wr_excl_done = 0; dn.err_wr = 0;
    cfg_lat_r = 0; cfg_lat_w = 0; cfg_cmd_gap = 0; cfg_max_out = 0;
    repeat (3) @(posedge clk);
    #1;
    hs_q.delete(); iss_q.delete(); iss_addr_q.delete();
    first_vld = -1;
    rst_a = 1'b0;
  endtask

  task automatic send_cmd(input logic rd, input logic [31:0] addr);
    bit acc = 0;
    up.cmd_valid = 1; up.cmd_read = rd; up.cmd_addr = addr;
    up.cmd_data_size = 3'd2; up.cmd_burst_size = 4'd3;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = up.cmd_accept;
      @(posedge clk);
      #1;
    end
    up.cmd_valid = 0;
    chk("send_acc", acc, 1);
  endtask

  task automatic wait_issues(input string tag, input int n, input int budget);
    int i = 0;
    while (iss_q.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(tag, iss_q.size(), n);
  endtask

  function automatic int order_errs(input int n, input logic [31:0] base);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= iss_addr_q.size() || iss_addr_q[i] !== base + 32'(i * 4)) e++;
    end
    return e;
  endfunction

  initial begin
    int k;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state and pass-through while in reset.
    rst_a = 1'b1;
    do_reset();
    rst_a = 1'b1;
    up.wr_valid = 1; up.wr_data = 32'hA5A5_0001; up.wr_mask = 4'hC;
    dn.wr_done = 1; dn.rd_data = 32'h1234_5678;
    @(negedge clk);
    chk("rst_cmd_accept", up.cmd_accept, 0);
    chk("rst_cmd_valid", dn.cmd_valid, 0);
    chk("rst_stat_cmd", stat_cmd_cnt, 0);
    chk("rst_stat_stall", stat_stall_cnt, 0);
    chk("pt_wr_valid", dn.wr_valid, 1);
    chk("pt_wr_data", dn.wr_data, 32'hA5A5_0001);
    chk("pt_wr_mask", dn.wr_mask, 4'hC);
    chk("pt_wr_done", up.wr_done, 1);
    chk("pt_rd_data", up.rd_data, 32'h1234_5678);

    do_reset();
    @(negedge clk);
    chk("accept_deassert_cycle", up.cmd_accept, 0);
    @(negedge clk);
    chk("accept_one_after", up.cmd_accept, 1);

    // Read latency 10.
    @(posedge clk); #1;
    cfg_lat_r = 12'd10;
    send_cmd(1'b1, 32'h0000_1234);
    wait_issues("t1_issued", 1, 50);
    chk("t1_latency", iss_q[0] - hs_q[0], 10);
    chk("t1_addr", iss_addr_q[0], 32'h0000_1234);
    chk("t1_read", iss_read, 1);
    chk("t1_size", iss_ds, 3'd2);
    chk("t1_burst", iss_bs, 4'd3);

    // Latency 0, back-to-back reads.
    do_reset();
    @(posedge clk); #1;
    send_cmd(1'b1, 32'h100);
    send_cmd(1'b1, 32'h104);
    send_cmd(1'b1, 32'h108);
    wait_issues("t2_issued", 3, 50);
    chk("t2_hs_b2b", hs_q[2] - hs_q[0], 2);
    chk("t2_lat0", iss_q[0] - hs_q[0], 1);
    chk("t2_lat1", iss_q[1] - hs_q[1], 1);
    chk("t2_lat2", iss_q[2] - hs_q[2], 1);
    chk("t2_order", order_errs(3, 32'h100), 0);

    // Write latency 3 with gap 4.
    do_reset();
    cfg_lat_w = 12'd3; cfg_cmd_gap = 8'd4;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 32'h200 + 32'(i * 4));
    wait_issues("t3_issued", 4, 100);
    chk("t3_first", iss_q[0] - hs_q[0], 3);
    chk("t3_gap1", iss_q[1] - iss_q[0], 5);
    chk("t3_gap2", iss_q[2] - iss_q[1], 5);
    chk("t3_gap3", iss_q[3] - iss_q[2], 5);
    chk("t3_order", order_errs(4, 32'h200), 0);

    // Outstanding cap of 2 with three 4-beat reads.
    do_reset();
    cfg_max_out = 8'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_cmd(1'b1, 32'h300 + 32'(i * 4));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_held_count", iss_q.size(), 2);
    chk("t4_held_valid", dn.cmd_valid, 0);
    @(posedge clk); #1;
    k = 0;
    for (int b = 0; b < 4; b++) begin
      dn.rd_valid = 1; dn.rd_last = (b == 3); dn.rd_data = 32'hD0 + 32'(b);
      @(negedge clk);
      if (b == 3) k = cyc;
      if (b == 1) chk("t4_rd_pass", up.rd_data, 32'hD1);
      @(posedge clk); #1;
    end
    dn.rd_valid = 0; dn.rd_last = 0;
    wait_issues("t4_issued", 3, 20);
    chk("t4_release", iss_q[2] - k, 1);
    repeat (2) @(posedge clk);
    #1;
`ifdef ALB_MSS_FAB_IBP_DLY_STATS_EN
    chk("t4_stall_cnt", stat_stall_cnt, 64'(k - hs_q[2]));
    chk("t4_cmd_cnt", stat_cmd_cnt, 3);
`else
    chk("t4_stall_off", stat_stall_cnt, 0);
    chk("t4_cmd_off", stat_cmd_cnt, 0);
`endif

    // Fill all 32 entries with the slave stalled.
    do_reset();
    dn.cmd_accept = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) send_cmd(1'b0, 32'h1000 + 32'(i * 4));
    @(negedge clk);
    chk("t5_full", up.cmd_accept, 0);
    @(posedge clk); #1;
    up.cmd_valid = 1; up.cmd_addr = 32'hDEAD;
    repeat (3) @(posedge clk);
    #1;
    up.cmd_valid = 0;
    chk("t5_hs_count", hs_q.size(), 32);
    dn.cmd_accept = 1;
    @(negedge clk);
    chk("t5_issue_cycle_acc", up.cmd_accept, 0);
    chk("t5_issue_cycle_vld", dn.cmd_valid, 1);
    @(negedge clk);
    chk("t5_acc_rise", up.cmd_accept, 1);
    wait_issues("t5_issued", 32, 100);
    chk("t5_order", order_errs(32, 32'h1000), 0);

    // Maximum write latency across timestamp wrap.
    do_reset();
    cfg_lat_w = 12'd4095;
    dn.cmd_accept = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_cmd(1'b0, 32'h2000 + 32'(i * 4));
    repeat (10000) @(posedge clk);
    @(negedge clk);
    chk("t6_first_vld", first_vld - hs_q[0], 4095);
    chk("t6_still_vld", dn.cmd_valid, 1);
    chk("t6_none_early", iss_q.size(), 0);
    @(posedge clk); #1;
    dn.cmd_accept = 1;
    wait_issues("t6_issued", 3, 20);
    chk("t6_b2b", iss_q[2] - iss_q[0], 2);
    chk("t6_order", order_errs(3, 32'h2000), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
